// File: rtl/se_pkg.sv
// se_pkg: shared types and defaults for the sound-effect tone generator.
package se_pkg;
    typedef enum logic [1:0] {SE_TONE_IDLE, SE_TONE_RUN, SE_TONE_DRAIN} se_tone_state_t;
    localparam int unsigned SE_CLK_HZ = 50_000_000;
    typedef logic [15:0] se_freq_t;
    function automatic se_freq_t se_clamp(se_freq_t f, se_freq_t lim);
        return (f > lim) ? lim : f;
    endfunction
endpackage

// File: rtl/se_phase_acc.sv
// se_phase_acc: phase accumulator; wrap fires when acc+step reaches CLK_HZ (one half-period).
module se_phase_acc #(
    parameter int unsigned CLK_HZ = se_pkg::SE_CLK_HZ,
    parameter int unsigned ACC_W  = 32
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             clear,
    input  logic             run,
    input  logic             load_step,
    input  logic [ACC_W-1:0] new_step,
    output logic             wrap,
    output logic [ACC_W-1:0] acc
);
    localparam logic [ACC_W:0] LIMIT = (ACC_W+1)'(CLK_HZ);
    logic [ACC_W-1:0] step;
    logic [ACC_W:0]   sum;
    assign sum  = {1'b0, acc} + {1'b0, step};
    assign wrap = sum >= LIMIT;
    always_ff @(posedge iClock) begin
        if (iReset) begin
            acc  <= '0;
            step <= '0;
        end else begin
            acc <= clear ? '0 : run ? (wrap ? ACC_W'(sum - LIMIT) : sum[ACC_W-1:0]) : acc;
            if (load_step) step <= new_step;
        end
    end
endmodule

// File: rtl/se_tone_gen.sv
// se_tone_gen: square-wave tone synthesiser with glitch-free pitch changes.
// Define SE_TONE_SOFTSTOP_EN to let the last high half-period finish (DRAIN) on stop.
module se_tone_gen
    import se_pkg::*;
#(
    parameter int unsigned CLK_HZ   = SE_CLK_HZ,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned MAX_FREQ = 20000
) (
    input  logic     iClock,
    input  logic     iReset,
    input  logic     iEnable,
    input  se_freq_t iFreq,
    output logic     oAudio,
    output logic     oActive,
    output logic     oToggle
);
    se_tone_state_t   state, state_n;
    logic             wrap, clear, run, load_step, freq_ok, audio_n;
    logic [ACC_W-1:0] new_step;
    assign freq_ok  = iFreq != '0;
    assign new_step = ACC_W'(se_clamp(iFreq, se_freq_t'(MAX_FREQ))) << 1;
    assign run      = state != SE_TONE_IDLE;
    assign clear    = state_n == SE_TONE_IDLE;
    se_phase_acc #(.CLK_HZ(CLK_HZ), .ACC_W(ACC_W)) u_acc (
        .iClock    (iClock),
        .iReset    (iReset),
        .clear     (clear),
        .run       (run),
        .load_step (load_step),
        .new_step  (new_step),
        .wrap      (wrap),
        .acc       ()
    );
    // Any toggle is applied first; stop decisions then see the post-toggle level.
    always_comb begin
        state_n   = state;
        load_step = 1'b0;
        audio_n   = (run && wrap) ? ~oAudio : oAudio;
        case (state)
            SE_TONE_IDLE: begin
                audio_n = 1'b0;
                if (iEnable && freq_ok) begin
                    state_n   = SE_TONE_RUN;
                    load_step = 1'b1;
                end
            end
            SE_TONE_RUN: begin
                load_step = wrap && freq_ok;
                if (!iEnable || (wrap && !freq_ok)) begin
`ifdef SE_TONE_SOFTSTOP_EN
                    state_n = audio_n ? SE_TONE_DRAIN : SE_TONE_IDLE;
`else
                    state_n = SE_TONE_IDLE;
                    audio_n = 1'b0;
`endif
                end
            end
`ifdef SE_TONE_SOFTSTOP_EN
            SE_TONE_DRAIN: begin
                if (iEnable && freq_ok) begin
                    state_n   = SE_TONE_RUN;
                    load_step = wrap;
                end else if (wrap) begin
                    state_n = SE_TONE_IDLE;
                end
            end
`endif
            default: state_n = SE_TONE_IDLE;
        endcase
    end
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state   <= SE_TONE_IDLE;
            oAudio  <= 1'b0;
            oActive <= 1'b0;
            oToggle <= 1'b0;
        end else begin
            state   <= state_n;
            oAudio  <= audio_n;
            oActive <= state_n != SE_TONE_IDLE;
            oToggle <= audio_n != oAudio;
        end
    end
endmodule

// File: tb/tb_se_tone_gen.sv
// tb_se_tone_gen: table-driven check of se_tone_gen at CLK_HZ=1000, MAX_FREQ=200.
module tb_se_tone_gen;
    logic        clk = 1'b0;
    logic        rst, en, audio, active, tgl;
    logic [15:0] freq;
    int          tests = 0, fails = 0;
    always #5 clk = ~clk;
    se_tone_gen #(.CLK_HZ(1000), .ACC_W(32), .MAX_FREQ(200)) dut (
        .iClock  (clk),
        .iReset  (rst),
        .iEnable (en),
        .iFreq   (freq),
        .oAudio  (audio),
        .oActive (active),
        .oToggle (tgl)
    );
    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] freq;
        logic        audio;
        logic        active;
        logic        tgl;
        string       name;
    } vec_t;
    vec_t vecs[$];
    task automatic add(int n, logic r, logic e, logic [15:0] f, logic a, logic act, logic t, string nm);
        vec_t v;
        v.rst = r; v.en = e; v.freq = f; v.audio = a; v.active = act; v.tgl = t; v.name = nm;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask
    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    task automatic tick(logic r, logic e, logic [15:0] f);
        rst = r; en = e; freq = f;
        @(posedge clk);
        #1;
    endtask
    task automatic chk3(string nm, logic a, logic act, logic t);
        chk({nm, "_audio"}, 32'(audio), 32'(a));
        chk({nm, "_active"}, 32'(active), 32'(act));
        chk({nm, "_toggle"}, 32'(tgl), 32'(t));
    endtask
    initial begin
        int n;
        rst = 1'b1; en = 1'b0; freq = '0;
        add(3, 1, 1, 100,  0, 0, 0, "reset");
        add(1, 0, 1, 100,  0, 1, 0, "run_entry");
        add(4, 0, 1, 100,  0, 1, 0, "pre_rise");
        add(1, 0, 1, 100,  1, 1, 1, "rise1");
        add(4, 0, 1, 100,  1, 1, 0, "high1");
        add(1, 0, 1, 100,  0, 1, 1, "fall1");
        add(4, 0, 1, 100,  0, 1, 0, "low1");
        add(1, 0, 1, 100,  1, 1, 1, "rise2");
        add(4, 0, 1, 50,   1, 1, 0, "old_step_high");
        add(1, 0, 1, 50,   0, 1, 1, "old_step_fall");
        add(9, 0, 1, 50,   0, 1, 0, "new_step_low");
        add(1, 0, 1, 50,   1, 1, 1, "new_step_rise");
        add(9, 0, 1, 1000, 1, 1, 0, "pre_clamp_high");
        add(1, 0, 1, 1000, 0, 1, 1, "pre_clamp_fall");
        for (int k = 0; k < 2; k++) begin
            add(2, 0, 1, 1000, 0, 1, 0, "clamp_low");
            add(1, 0, 1, 1000, 1, 1, 1, "clamp_rise3");
            add(1, 0, 1, 1000, 1, 1, 0, "clamp_high");
            add(1, 0, 1, 1000, 0, 1, 1, "clamp_fall2");
        end
        add(1, 0, 0, 1000, 0, 0, 0, "stop_low");
        add(3, 0, 1, 0,    0, 0, 0, "freq0_idle");
        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].en, vecs[i].freq);
            chk3(vecs[i].name, vecs[i].audio, vecs[i].active, vecs[i].tgl);
        end
        // enable dropped one cycle after a rise
        tick(0, 1, 100);
        chk3("t5_entry", 0, 1, 0);
        n = 0;
        while (!audio && n < 20) begin
            tick(0, 1, 100);
            n++;
        end
        chk("t5_rise_delay", 32'(n), 32'd5);
        tick(0, 1, 100);
        chk3("t5_hold", 1, 1, 0);
        tick(0, 0, 100);
`ifdef SE_TONE_SOFTSTOP_EN
        chk3("t5_drain1", 1, 1, 0);
        tick(0, 0, 100);
        chk3("t5_drain2", 1, 1, 0);
        tick(0, 0, 100);
        chk3("t5_drain3", 1, 1, 0);
        tick(0, 0, 100);
        chk3("t5_drain_fall", 0, 0, 1);
`else
        chk3("t5_hard_stop", 0, 0, 1);
`endif
        tick(0, 0, 100);
        chk3("t5_idle", 0, 0, 0);
        // reset while high mid-tone
        tick(0, 1, 100);
        n = 0;
        while (!audio && n < 20) begin
            tick(0, 1, 100);
            n++;
        end
        chk("t6_rise_delay", 32'(n), 32'd5);
        tick(0, 1, 100);
        tick(1, 1, 100);
        chk3("t6_reset", 0, 0, 0);
        chk("t6_acc", dut.u_acc.acc, 32'd0);
        tick(0, 0, 0);
        chk3("t6_after_reset", 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
